// File: rtl/ahb_ext_mem_backend.sv
// rtl/ahb_ext_mem_backend.sv - wait-stated word memory with posted write buffer behind the AHB slave
module ahb_ext_mem_backend #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 2,
    parameter int WBUF_DEPTH  = 4
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  Write,
    input  logic                  Read,
    input  logic [ADDR_WIDTH-1:0] AddressOUT,
    input  logic [DATA_WIDTH-1:0] OutputData,
    output logic [DATA_WIDTH-1:0] InData,
    output logic                  ValidRead,
    output logic                  StopOp,
    output logic                  ReadyToWork
);
    localparam int MW = $clog2(MEM_DEPTH);
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int IW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, RD_DRAIN, RD_WAIT, RD_DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem     [MEM_DEPTH];
    logic [MW-1:0]         wb_idx  [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] wb_data [WBUF_DEPTH];
    logic [PW:0]           wr_ptr;
    logic [PW:0]           rd_ptr;
    logic [3:0]            wcnt;
    logic [3:0]            rcnt;
    logic [MW-1:0]         rd_idx;

    logic [IW-1:0] idx;
    logic          empty;
    logic          full;
    logic          take;
    logic          bad;
    logic          push;
    logic          drain_fire;

    assign idx   = AddressOUT[ADDR_WIDTH-1:2];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign ReadyToWork = (state == IDLE) && !full;
    assign take        = ReadyToWork && (Write || Read);
    assign bad         = (Write && Read) || (AddressOUT[1:0] != 2'b00) || (idx >= IW'(MEM_DEPTH));
    assign push        = take && !bad && Write;
    // Head entry commits on the last cycle of its wait window.
    assign drain_fire  = !empty && (wcnt == 4'(WAIT_STATES));

    always_ff @(posedge HCLK) begin
        if (push) begin
            wb_idx[wr_ptr[PW-1:0]]  <= idx[MW-1:0];
            wb_data[wr_ptr[PW-1:0]] <= OutputData;
        end
    end

    always_ff @(posedge HCLK) begin
        if (drain_fire) begin
            mem[wb_idx[rd_ptr[PW-1:0]]] <= wb_data[rd_ptr[PW-1:0]];
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wcnt      <= '0;
            rcnt      <= '0;
            rd_idx    <= '0;
            InData    <= '0;
            ValidRead <= 1'b0;
            StopOp    <= 1'b0;
        end else begin
            ValidRead <= 1'b0;
            StopOp    <= take && bad;

            if (push) begin
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (!empty) begin
                if (drain_fire) begin
                    rd_ptr <= rd_ptr + (PW+1)'(1);
                    wcnt   <= '0;
                end else begin
                    wcnt <= wcnt + 4'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (take && !bad && Read) begin
                        state  <= RD_DRAIN;
                        rd_idx <= idx[MW-1:0];
                    end
                end
                RD_DRAIN: begin
                    // Reads only proceed once every earlier posted write has landed.
                    if (empty) begin
                        if (WAIT_STATES == 0) begin
                            InData    <= mem[rd_idx];
                            ValidRead <= 1'b1;
                            state     <= RD_DONE;
                        end else begin
                            rcnt  <= '0;
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (rcnt == 4'(WAIT_STATES - 1)) begin
                        InData    <= mem[rd_idx];
                        ValidRead <= 1'b1;
                        state     <= RD_DONE;
                    end else begin
                        rcnt <= rcnt + 4'd1;
                    end
                end
                RD_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_ext_mem_backend.sv
// tb/tb_ahb_ext_mem_backend.sv - directed bench with transaction-level reference model
module tb_ahb_ext_mem_backend;
    localparam int WS = 2;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        wr = 1'b0, rd = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] indata;
    logic        vr, stop, rdy;

    logic        rst15 = 1'b1;
    logic        wr15 = 1'b0, rd15 = 1'b0;
    logic [31:0] addr15 = '0, wdata15 = '0;
    logic [31:0] indata15;
    logic        vr15, stop15, rdy15;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ahb_ext_mem_backend #(.WAIT_STATES(WS)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .Write(wr), .Read(rd), .AddressOUT(addr),
        .OutputData(wdata), .InData(indata), .ValidRead(vr), .StopOp(stop), .ReadyToWork(rdy)
    );

    ahb_ext_mem_backend #(.WAIT_STATES(15)) dut15 (
        .HCLK(HCLK), .HRESET(rst15), .Write(wr15), .Read(rd15), .AddressOUT(addr15),
        .OutputData(wdata15), .InData(indata15), .ValidRead(vr15), .StopOp(stop15), .ReadyToWork(rdy15)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: each posted write finishes WS+1 cycles after the later of its push and
    // the previous write's finish; a read returns WS+1 cycles after the buffer has emptied.
    typedef struct {int done; int idx; logic [31:0] data;} went_t;
    went_t       q[$];
    logic [31:0] mm [256];
    bit          kn [256];
    int          last_done = 0;
    int          rd_v = -100;
    int          rd_i = 0;
    logic        exp_ready = 1'b1, exp_valid = 1'b0, exp_stop = 1'b0;
    logic [31:0] exp_data = '0;
    bit          data_known = 1'b1;

    always @(posedge HCLK or posedge HRESET) begin : model
        int t, ai;
        bit pre_ready;
        went_t e;
        if (HRESET) begin
            q.delete();
            last_done = 0;
            rd_v = -100;
            exp_ready = 1'b1; exp_valid = 1'b0; exp_stop = 1'b0;
            exp_data = '0; data_known = 1'b1;
        end else begin
            t = cyc + 1;
            while (q.size() > 0 && q[0].done <= t - 1) begin
                mm[q[0].idx] = q[0].data; kn[q[0].idx] = 1'b1; void'(q.pop_front());
            end
            pre_ready = !(t - 1 <= rd_v) && (q.size() < 4);
            exp_valid = 1'b0;
            exp_stop  = 1'b0;
            if (pre_ready && (wr || rd)) begin
                ai = int'(addr[31:2]);
                if ((wr && rd) || addr[1:0] != 2'b00 || ai >= 256) begin
                    exp_stop = 1'b1;
                end else if (wr) begin
                    e.done = ((t > last_done) ? t : last_done) + WS + 1;
                    e.idx = ai; e.data = wdata;
                    last_done = e.done;
                    q.push_back(e);
                end else begin
                    rd_v = ((t > last_done) ? t : last_done) + 1 + WS;
                    rd_i = ai;
                end
            end
            if (t == rd_v) begin
                exp_valid = 1'b1;
                data_known = kn[rd_i];
                if (kn[rd_i]) exp_data = mm[rd_i];
            end
            while (q.size() > 0 && q[0].done <= t) begin
                mm[q[0].idx] = q[0].data; kn[q[0].idx] = 1'b1; void'(q.pop_front());
            end
            exp_ready = !(t <= rd_v) && (q.size() < 4);
        end
    end

    always @(negedge HCLK) begin
        if (HRESET) begin
            check("rst_indata", indata, 32'h0);
            check("rst_valid", vr, 1'b0);
            check("rst_stop", stop, 1'b0);
            check("rst_ready", rdy, 1'b1);
        end else begin
            check("m_ready", rdy, exp_ready);
            check("m_valid", vr, exp_valid);
            check("m_stop", stop, exp_stop);
            if (data_known) check("m_indata", indata, exp_data);
        end
    end

    task automatic drive(input bit sel, input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        if (sel) begin wr15 = w; rd15 = r; addr15 = a; wdata15 = d; end
        else begin wr = w; rd = r; addr = a; wdata = d; end
    endtask

    task automatic req(input bit sel, input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, output int acc);
        logic s;
        acc = -1;
        drive(sel, w, r, a, d);
        for (int n = 0; n < 300; n++) begin
            @(negedge HCLK);
            s = sel ? rdy15 : rdy;
            @(posedge HCLK);
            if (s) begin acc = cyc + 1; break; end
        end
        #1;
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        check("req_accepted", (acc >= 0), 1'b1);
    endtask

    task automatic wait_valid(input bit sel, input int bound, output int edge_n, output logic [31:0] data);
        edge_n = -1;
        data = '0;
        for (int n = 0; n < bound; n++) begin
            @(negedge HCLK);
            if (sel ? vr15 : vr) begin edge_n = cyc; data = sel ? indata15 : indata; break; end
        end
        check("valid_seen", (edge_n >= 0), 1'b1);
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    initial begin
        int a0, a1, a2, c, ve, pulses;
        int acc15 [5];
        logic [31:0] d;
        logic [31:0] ea [3];
        logic        ew [3];
        logic        er [3];
        ea[0] = 32'h400; ew[0] = 1'b0; er[0] = 1'b1;
        ea[1] = 32'h002; ew[1] = 1'b1; er[1] = 1'b0;
        ea[2] = 32'h040; ew[2] = 1'b1; er[2] = 1'b1;

        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        rst15 = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            check("t1_indata", indata, 32'h0);
            check("t1_valid", vr, 1'b0);
            check("t1_stop", stop, 1'b0);
            check("t1_ready", rdy, 1'b1);
        end
        @(posedge HCLK); #1;

        // Write then read back
        req(0, 1, 0, 32'h10, 32'h1234, a0);
        req(0, 0, 1, 32'h10, 32'h0, a1);
        check("t2_b2b", a1 - a0, 32'd1);
        wait_valid(0, 50, ve, d);
        check("t2_latency", ve - a1, 32'd5);
        check("t2_data", d, 32'h1234);
        idle(3);

        // Same-address write ordering
        req(0, 1, 0, 32'h20, 32'h1111, a0);
        req(0, 1, 0, 32'h20, 32'h2222, a1);
        req(0, 0, 1, 32'h20, 32'h0, a2);
        wait_valid(0, 50, ve, d);
        check("t4_latency", ve - a2, 32'd7);
        check("t4_data", d, 32'h2222);
        idle(3);

        // Error requests
        for (int i = 0; i < 3; i++) begin
            req(0, ew[i], er[i], ea[i], 32'hDEAD, a0);
            @(negedge HCLK);
            check("t5_stop", stop, 1'b1);
            check("t5_novalid", vr, 1'b0);
            @(negedge HCLK);
            check("t5_stop_off", stop, 1'b0);
            @(posedge HCLK); #1;
        end

        // Rejected write while buffer is busy must not occupy a slot
        req(0, 1, 0, 32'h40, 32'h40, a0);
        req(0, 1, 0, 32'h44, 32'h44, a1);
        req(0, 1, 0, 32'h48, 32'h48, a1);
        req(0, 1, 0, 32'h02, 32'hBAD, a1);
        check("t5_err_edge", a1 - a0, 32'd3);
        req(0, 1, 0, 32'h4C, 32'h4C, a1);
        @(negedge HCLK);
        check("t5_count_kept", rdy, 1'b1);
        @(posedge HCLK); #1;
        req(0, 0, 1, 32'h48, 32'h0, a2);
        wait_valid(0, 60, ve, d);
        check("t5_readback", d, 32'h48);
        idle(3);

        // Reset during RD_WAIT abandons the read
        req(0, 0, 1, 32'h50, 32'h0, c);
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        idle(2);
        HRESET = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            if (vr) pulses++;
        end
        check("t6_no_valid", pulses, 32'd0);
        check("t6_ready", rdy, 1'b1);
        @(posedge HCLK); #1;
        req(0, 0, 1, 32'h84, 32'h0, c);
        wait_valid(0, 50, ve, d);
        check("t6_next_latency", ve - c, 32'd3);

        // Reset in the middle of a drain discards the posted write
        req(0, 1, 0, 32'h10, 32'h5555, a0);
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        idle(3);
        HRESET = 1'b0;
        req(0, 0, 1, 32'h10, 32'h0, c);
        wait_valid(0, 50, ve, d);
        check("t6_drain_lost", d, 32'h1234);
        idle(3);

        // Long wait states on the second instance
        for (int i = 0; i < 4; i++) req(1, 1, 0, 32'(i * 4), 32'hA0 + 32'(i), acc15[i]);
        check("t3_b2b", acc15[3] - acc15[0], 32'd3);
        @(negedge HCLK);
        check("t3_full", rdy15, 1'b0);
        req(1, 1, 0, 32'h10, 32'hA4, acc15[4]);
        check("t3_held", acc15[4] - acc15[0], 32'd17);
        for (int i = 0; i < 5; i++) begin
            req(1, 0, 1, 32'(i * 4), 32'h0, c);
            wait_valid(1, 200, ve, d);
            check("t3_readback", d, 32'hA0 + 32'(i));
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end
endmodule
